// File: rtl/data_link_pkg.sv
// Shared types and defaults for the data source/sink link.
// Provides default widths, the sink state enum and the default depth.
package data_link_pkg;

    localparam int AW_DEF    = 4;
    localparam int DW_DEF    = 4;
    localparam int ECW_DEF   = 8;
    localparam int DEPTH_DEF = 1 << AW_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_e;

endpackage

// File: rtl/sink_checker.sv
// Stream integrity checker: flags beats whose data differs from the address
// or whose address does not follow the previous one (mod DEPTH).
// Ports: clk, rst_n, clr, accept (beat taken), addr_in, data_in,
//        err_count (saturating), seq_err (sticky).
import data_link_pkg::*;

module sink_checker #(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int ECW = ECW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          accept,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic [ECW-1:0] err_count,
    output logic          seq_err
);

    logic [AW-1:0]  prev_q, prev_d;
    logic           have_prev_q, have_prev_d;
    logic [ECW-1:0] err_q, err_d;
    logic           seq_err_q, seq_err_d;
    logic [DW-1:0]  exp_data;
    logic [AW-1:0]  nxt_addr;
    logic           bad;

    generate
        if (DW <= AW) begin : g_trunc
            assign exp_data = addr_in[DW-1:0];
        end else begin : g_zext
            assign exp_data = {{(DW-AW){1'b0}}, addr_in};
        end
    endgenerate

    assign nxt_addr = prev_q + 1'b1;
    assign bad = (data_in != exp_data) ||
                 (have_prev_q && (addr_in != nxt_addr));

    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        err_d       = err_q;
        seq_err_d   = seq_err_q;
        if (clr) begin
            prev_d      = '0;
            have_prev_d = 1'b0;
            err_d       = '0;
            seq_err_d   = 1'b0;
        end else if (accept) begin
            prev_d      = addr_in;
            have_prev_d = 1'b1;
            // both error kinds on one beat still count once
            if (bad) begin
                seq_err_d = 1'b1;
                if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            err_q       <= err_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign err_count = err_q;
    assign seq_err   = seq_err_q;

endmodule

// File: rtl/data_sink.sv
// Receiving end of the addr/data beat stream: fills a DEPTH x DW register
// file, tracks filled addresses and raises full once all are written.
// Ports: clk, rst_n, ena_in/addr_in/data_in (beat), clr, rd_addr/rd_data
//        (1-cycle read), busy, full, rx_count, err_count, seq_err.
// Optional checker enabled by defining SINK_CHECK_EN.
import data_link_pkg::*;

module data_sink #(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int ECW = ECW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena_in,
    input  logic [AW-1:0]  addr_in,
    input  logic [DW-1:0]  data_in,
    input  logic           clr,
    input  logic [AW-1:0]  rd_addr,
    output logic [DW-1:0]  rd_data,
    output logic           busy,
    output logic           full,
    output logic [AW:0]    rx_count,
    output logic [ECW-1:0] err_count,
    output logic           seq_err
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] RX_MAX = DEPTH[AW:0];

    state_e           state_q, state_d;
    logic [DEPTH-1:0] mask_q, mask_d;
    logic [AW:0]      rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             full_q, full_d;
    logic [DW-1:0]    rd_data_q;
    logic             accept;
    logic [DW-1:0]    mem [DEPTH];

    // clr wins over a simultaneous beat
    assign accept = ena_in && !clr && (state_q != FULL);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        rx_d    = rx_q;
        if (clr) begin
            state_d = IDLE;
            mask_d  = '0;
            rx_d    = '0;
        end else if (accept) begin
            mask_d[addr_in] = 1'b1;
            if (rx_q != RX_MAX) begin
                rx_d = rx_q + 1'b1;
            end
            state_d = (&mask_d) ? FULL : RECV;
        end
        busy_d = (state_d == RECV);
        full_d = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            rx_q      <= rx_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            // reads see pre-write contents on same-address collision
            rd_data_q <= mem[rd_addr];
        end
    end

    // storage has no reset; contents survive reset and clr
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[addr_in] <= data_in;
        end
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign rx_count = rx_q;

`ifdef SINK_CHECK_EN
    sink_checker #(
        .AW (AW),
        .DW (DW),
        .ECW(ECW)
    ) u_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .accept   (accept),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .err_count(err_count),
        .seq_err  (seq_err)
    );
`else
    assign err_count = '0;
    assign seq_err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_sink.sv
// Directed self-checking bench for data_sink.
// Expected checker results depend on SINK_CHECK_EN.
module tb_data_sink;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_in = 1'b0;
    logic [3:0] addr_in = '0;
    logic [3:0] data_in = '0;
    logic       clr = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       busy;
    logic       full;
    logic [4:0] rx_count;
    logic [7:0] err_count;
    logic       seq_err;

    int tests = 0;
    int fails = 0;

    data_sink dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena_in   (ena_in),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .clr      (clr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .full     (full),
        .rx_count (rx_count),
        .err_count(err_count),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int d);
        ena_in  = 1'b1;
        addr_in = a[3:0];
        data_in = d[3:0];
        cyc();
        ena_in  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic rd(input int a, output logic [3:0] v);
        rd_addr = a[3:0];
        cyc();
        v = rd_data;
    endtask

    logic [3:0] v;
    int exp_err;

    initial begin
        // reset state
        cyc();
        cyc();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_rx", rx_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_seq", seq_err, 0);
        rst_n = 1'b1;
        cyc();

        // 16 consecutive beats
        for (int i = 0; i < 15; i++) beat(i, i);
        chk("t1_full_pre", full, 0);
        chk("t1_busy_pre", busy, 1);
        beat(15, 15);
        chk("t1_full", full, 1);
        chk("t1_rx", rx_count, 16);
        chk("t1_busy", busy, 0);
        for (int k = 0; k < 16; k++) begin
            rd(k, v);
            chk($sformatf("t1_rd%0d", k), v, k);
        end
        chk("t1_err", err_count, 0);

        // pause in the middle of the stream
        do_clr();
        chk("t2_clr_full", full, 0);
        chk("t2_clr_rx", rx_count, 0);
        chk("t2_clr_busy", busy, 0);
        for (int i = 0; i < 8; i++) beat(i, i);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_gap_busy", busy, 1);
        end
        chk("t2_gap_full", full, 0);
        for (int i = 8; i < 16; i++) beat(i, i);
        chk("t2_full", full, 1);
        chk("t2_rx", rx_count, 16);
        chk("t2_err", err_count, 0);
        chk("t2_seq", seq_err, 0);

        // wrap-around start at 12, then ignored 17th beat
        do_clr();
        for (int i = 12; i < 28; i++) beat(i % 16, i % 16);
        chk("t3_full", full, 1);
        chk("t3_err", err_count, 0);
        beat(0, 9);
        chk("t3_rx", rx_count, 16);
        chk("t3_full2", full, 1);
        rd(0, v);
        chk("t3_mem0", v, 0);

        // checker: gap at 3, data mismatch at 4
        do_clr();
        beat(0, 0);
        beat(1, 1);
        beat(3, 3);
        beat(4, 7);
`ifdef SINK_CHECK_EN
        exp_err = 2;
`else
        exp_err = 0;
`endif
        chk("t4_err", err_count, exp_err);
        chk("t4_seq", seq_err, exp_err != 0);
        chk("t4_rx", rx_count, 4);
        chk("t4_busy", busy, 1);
        // rewrites still count; rx_count saturates at DEPTH
        for (int i = 0; i < 13; i++) beat(4, 4);
        chk("t4_rx_sat", rx_count, 16);
        chk("t4_full", full, 0);

        // clr with a simultaneous beat drops the beat
        do_clr();
        for (int i = 0; i < 8; i++) beat(i, i);
        chk("t5_rx8", rx_count, 8);
        clr = 1'b1;
        ena_in = 1'b1;
        addr_in = 4'd0;
        data_in = 4'd9;
        cyc();
        clr = 1'b0;
        ena_in = 1'b0;
        chk("t5_rx", rx_count, 0);
        chk("t5_full", full, 0);
        chk("t5_busy", busy, 0);
        chk("t5_err", err_count, 0);
        for (int k = 0; k < 8; k++) begin
            rd(k, v);
            chk($sformatf("t5_rd%0d", k), v, k);
        end

        // asynchronous reset mid-stream
        do_clr();
        for (int i = 0; i < 6; i++) beat(i, i);
        rd_addr = 4'd3;
        cyc();
        chk("t6_pre_rd", rd_data, 3);
        chk("t6_pre_rx", rx_count, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd", rd_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_rx", rx_count, 0);
        chk("t6_rst_err", err_count, 0);
        chk("t6_rst_seq", seq_err, 0);
        #1;
        rst_n = 1'b1;
        cyc();
        for (int i = 6; i < 16; i++) beat(i, i);
        chk("t6_mask_cleared", full, 0);
        chk("t6_rx10", rx_count, 10);
        for (int i = 0; i < 6; i++) beat(i, i);
        chk("t6_full", full, 1);
        chk("t6_rx", rx_count, 16);
        chk("t6_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
